exc_handler_cp0: RTL and testbench
==================================

# exc_handler_cp0

Exception responder and CP0 register file for the pipelined CPU. Consumes the `exc_type` code that the ALU and other stages attach to an instruction, commits it at the MEM/WB boundary, updates Status/Cause/EPC/BadVAddr, and drives a one-cycle pipeline flush with a redirect PC. It also handles ERET, the Count/Compare timer interrupt, and the `mtc0`/`mfc0` register port.

## Interface
- `EXC_TYPE_LENGTH`, default `` `EXC_TYPE_LENGTH ``: width of the exception-type code; encodings come from `definitions.v`.
- `EXC_VECTOR`, default 32'hBFC0_0380: redirect target for every exception except ERET.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `exc_type_i` in EXC_TYPE_LENGTH: exception code of the committing instruction; `EXC_TYPE_NONE` means no exception.
- `exc_pc_i` in 32: PC of the committing instruction.
- `exc_bd_i` in 1: the committing instruction is in a delay slot.
- `exc_badvaddr_i` in 32: faulting address for AdEL/AdES.
- `stall_i` in 1: pipeline stalled; nothing commits.
- `hw_int_i` in 6: level-sensitive external interrupts.
- `cp0_we_i` in 1, `cp0_waddr_i` in 5, `cp0_wdata_i` in 32: mtc0 write port.
- `cp0_raddr_i` in 5, `cp0_rdata_o` out 32: mfc0 read port (combinational).
- `flush_o` out 1: flush IF through MEM.
- `redirect_pc_o` out 32: next fetch PC, valid while `flush_o` = 1.
- `epc_o`, `status_o`, `cause_o` out 32: live register values.
- `timer_int_o` out 1: Count/Compare match pending.

## Operation
- Registers:
  - BadVAddr (8)
  - Count (9)
  - Compare (11)
  - Status (12): IM[15:8], EXL[1], IE[0]; other bits read 0.
  - Cause (13): BD[31], IP[15:8], ExcCode[6:2].
  - EPC (14)
  - Unimplemented addresses read 0.
- Writable fields:
  - Status IM/EXL/IE.
  - Cause IP[9:8] only.
  - EPC, Count and Compare in full.
  - BadVAddr is read-only.
- Writing Compare clears `timer_int_o`.
- Cause.IP[15:10] = {hw_int_i[5] | timer_int_o, hw_int_i[4:0]}, sampled every cycle.
- Interrupt pending when (IP & IM) != 0, IE = 1 and EXL = 0.
- FSM states RUN and FLUSH. Only RUN accepts events.
- In RUN with `stall_i` = 0, the event is, in priority order:
  - interrupt pending: ExcCode 0;
  - else `exc_type_i` == ERET;
  - else `exc_type_i` != NONE: ExcCode Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12, Tr=13.
- Exception (including interrupt):
  - If EXL = 0: EPC = `exc_bd_i` ? `exc_pc_i` − 4 : `exc_pc_i`, and BD = `exc_bd_i`. If EXL = 1, EPC and BD are held.
  - EXL is set to 1 and ExcCode is written.
  - BadVAddr = `exc_badvaddr_i` for AdEL/AdES only.
  - `redirect_pc_o` = EXC_VECTOR; go to FLUSH.
- ERET: EXL is cleared, `redirect_pc_o` = EPC (the value before this edge), go to FLUSH.
- FLUSH lasts exactly one cycle with `flush_o` = 1, then returns to RUN. `exc_type_i` is ignored during FLUSH.
- Count increments by 1 every cycle and wraps at 2^32.
- If Count == Compare and Compare != 0, `timer_int_o` is set; it is cleared only by a Compare write or reset.
- `cp0_rdata_o` bypasses a same-cycle write to the same address, showing the masked write data.
- An mtc0 write in the same cycle as an exception or ERET applies first; exception-written fields (EPC, BD, ExcCode, EXL, BadVAddr) override it.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - all CP0 registers become 0;
  - `timer_int_o` = 0, `flush_o` = 0, `redirect_pc_o` = 0, state = RUN;
  - reset during FLUSH aborts the flush at that edge.
- Latency:
  - an event accepted in cycle N updates registers at the end of N;
  - `flush_o` and `redirect_pc_o` are valid in cycle N+1;
  - `epc_o`, `status_o` and `cause_o` reflect the update from cycle N+1.
- `stall_i` = 1 blocks acceptance. A held `exc_type_i` is taken in the first unstalled RUN cycle.
- Back-to-back events: the earliest possible second acceptance is cycle N+2.
- Count is not stalled by `stall_i`.

## Test plan
- Ov at PC 0x0000_0100, EXL = 0, no BD: next cycle `flush_o` = 1, `redirect_pc_o` = 0xBFC0_0380, EPC = 0x100, ExcCode = 12, EXL = 1.
- Tr with `exc_bd_i` = 1 at PC 0x204: EPC = 0x200, BD = 1, ExcCode = 13. Then ERET: `redirect_pc_o` = 0x200 and EXL = 0.
- Second exception (RI) while EXL = 1: EPC unchanged, ExcCode = 10, still redirects to 0xBFC0_0380.
- Write Compare = 5 with Count = 0: `timer_int_o` rises when Count = 5. With IE = 1 and IM7 = 1, the next commit becomes ExcCode 0. Writing Compare clears `timer_int_o`.
- Sys held for 3 stall cycles, then unstalled: exactly one flush, one cycle after stall release. Assert `rst_n` = 0 during that FLUSH: `flush_o` = 0 next cycle and all registers read 0.
- Same-cycle mtc0 EPC = 0x1234 and Ov at 0x300: EPC = 0x300. A same-cycle mfc0 read of Status during a write returns the masked write data.

Source files
------------

// File: rtl/exc_handler_cp0.sv
// CP0 register file and exception responder: commits exceptions/ERET at MEM/WB,
// maintains Status/Cause/EPC/BadVAddr/Count/Compare and issues a one-cycle flush with a redirect PC.
module exc_handler_cp0 #(
  parameter int EXC_TYPE_LENGTH = 4,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_NONE = EXC_TYPE_LENGTH'(0),
  parameter logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_INT  = EXC_TYPE_LENGTH'(1),
  parameter logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_ADEL = EXC_TYPE_LENGTH'(2),
  parameter logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_ADES = EXC_TYPE_LENGTH'(3),
  parameter logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_SYS  = EXC_TYPE_LENGTH'(4),
  parameter logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_BP   = EXC_TYPE_LENGTH'(5),
  parameter logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_RI   = EXC_TYPE_LENGTH'(6),
  parameter logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_OV   = EXC_TYPE_LENGTH'(7),
  parameter logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_TR   = EXC_TYPE_LENGTH'(8),
  parameter logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_ERET = EXC_TYPE_LENGTH'(9)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [EXC_TYPE_LENGTH-1:0] exc_type_i,
  input  logic [31:0]                exc_pc_i,
  input  logic                       exc_bd_i,
  input  logic [31:0]                exc_badvaddr_i,
  input  logic                       stall_i,
  input  logic [5:0]                 hw_int_i,
  input  logic                       cp0_we_i,
  input  logic [4:0]                 cp0_waddr_i,
  input  logic [31:0]                cp0_wdata_i,
  input  logic [4:0]                 cp0_raddr_i,
  output logic [31:0]                cp0_rdata_o,
  output logic                       flush_o,
  output logic [31:0]                redirect_pc_o,
  output logic [31:0]                epc_o,
  output logic [31:0]                status_o,
  output logic [31:0]                cause_o,
  output logic                       timer_int_o,
  output logic                       dbg_state_o
);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_STATUS   = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  logic [0:0]  r_state;
  logic [31:0] r_badvaddr;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [31:0] r_epc;
  logic [7:0]  r_status_im;
  logic        r_status_exl;
  logic        r_status_ie;
  logic        r_cause_bd;
  logic [7:0]  r_cause_ip;
  logic [4:0]  r_cause_exccode;
  logic        r_timer_int;
  logic [31:0] r_redirect_pc;

  logic        w_int_pending;
  logic        w_accept;
  logic        w_take_exc;
  logic        w_take_eret;
  logic        w_is_addr_exc;
  logic [4:0]  w_exc_code;
  logic [4:0]  w_type_code;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic        w_wr_cause;
  logic        w_wr_epc;
  logic [31:0] w_rd_reg;

  assign w_int_pending = (|(r_cause_ip & r_status_im)) && r_status_ie && !r_status_exl;
  assign w_accept      = (r_state == S_RUN) && !stall_i;
  // A pending interrupt preempts whatever instruction is committing this cycle.
  assign w_take_eret   = w_accept && !w_int_pending && (exc_type_i == EXC_TYPE_ERET);
  assign w_take_exc    = w_accept && (w_int_pending ||
                         ((exc_type_i != EXC_TYPE_NONE) && (exc_type_i != EXC_TYPE_ERET)));
  assign w_is_addr_exc = !w_int_pending &&
                         ((exc_type_i == EXC_TYPE_ADEL) || (exc_type_i == EXC_TYPE_ADES));
  assign w_exc_code    = w_int_pending ? 5'd0 : w_type_code;

  always_comb begin
    w_type_code = 5'd10;
    if (exc_type_i == EXC_TYPE_INT)       w_type_code = 5'd0;
    else if (exc_type_i == EXC_TYPE_ADEL) w_type_code = 5'd4;
    else if (exc_type_i == EXC_TYPE_ADES) w_type_code = 5'd5;
    else if (exc_type_i == EXC_TYPE_SYS)  w_type_code = 5'd8;
    else if (exc_type_i == EXC_TYPE_BP)   w_type_code = 5'd9;
    else if (exc_type_i == EXC_TYPE_RI)   w_type_code = 5'd10;
    else if (exc_type_i == EXC_TYPE_OV)   w_type_code = 5'd12;
    else if (exc_type_i == EXC_TYPE_TR)   w_type_code = 5'd13;
  end

  assign w_wr_count   = cp0_we_i && (cp0_waddr_i == A_COUNT);
  assign w_wr_compare = cp0_we_i && (cp0_waddr_i == A_COMPARE);
  assign w_wr_status  = cp0_we_i && (cp0_waddr_i == A_STATUS);
  assign w_wr_cause   = cp0_we_i && (cp0_waddr_i == A_CAUSE);
  assign w_wr_epc     = cp0_we_i && (cp0_waddr_i == A_EPC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_RUN;
      r_badvaddr      <= 32'd0;
      r_count         <= 32'd0;
      r_compare       <= 32'd0;
      r_epc           <= 32'd0;
      r_status_im     <= 8'd0;
      r_status_exl    <= 1'b0;
      r_status_ie     <= 1'b0;
      r_cause_bd      <= 1'b0;
      r_cause_ip      <= 8'd0;
      r_cause_exccode <= 5'd0;
      r_timer_int     <= 1'b0;
      r_redirect_pc   <= 32'd0;
    end else begin
      r_count <= w_wr_count ? cp0_wdata_i : r_count + 32'd1;
      if (w_wr_compare) r_compare <= cp0_wdata_i;

      // Sticky match flag; only a Compare write (or reset) clears it.
      if (w_wr_compare)
        r_timer_int <= 1'b0;
      else if ((r_count == r_compare) && (r_compare != 32'd0))
        r_timer_int <= 1'b1;

      r_cause_ip[7:2] <= {hw_int_i[5] | r_timer_int, hw_int_i[4:0]};
      if (w_wr_cause) r_cause_ip[1:0] <= cp0_wdata_i[9:8];

      if (w_wr_status) begin
        r_status_im  <= cp0_wdata_i[15:8];
        r_status_exl <= cp0_wdata_i[1];
        r_status_ie  <= cp0_wdata_i[0];
      end
      if (w_wr_epc) r_epc <= cp0_wdata_i;

      // Event updates come after the mtc0 writes so they take precedence.
      if (w_take_exc) begin
        if (!r_status_exl) begin
          r_epc      <= exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
          r_cause_bd <= exc_bd_i;
        end
        r_status_exl    <= 1'b1;
        r_cause_exccode <= w_exc_code;
        if (w_is_addr_exc) r_badvaddr <= exc_badvaddr_i;
        r_redirect_pc   <= EXC_VECTOR;
        r_state         <= S_FLUSH;
      end else if (w_take_eret) begin
        r_status_exl  <= 1'b0;
        r_redirect_pc <= r_epc;
        r_state       <= S_FLUSH;
      end else begin
        r_state <= S_RUN;
      end
    end
  end

  assign status_o      = {16'd0, r_status_im, 6'd0, r_status_exl, r_status_ie};
  assign cause_o       = {r_cause_bd, 15'd0, r_cause_ip, 1'b0, r_cause_exccode, 2'b00};
  assign epc_o         = r_epc;
  assign timer_int_o   = r_timer_int;
  assign flush_o       = (r_state == S_FLUSH);
  assign redirect_pc_o = r_redirect_pc;
  assign dbg_state_o   = r_state;

  always_comb begin
    w_rd_reg = 32'd0;
    case (cp0_raddr_i)
      A_BADVADDR: w_rd_reg = r_badvaddr;
      A_COUNT:    w_rd_reg = r_count;
      A_COMPARE:  w_rd_reg = r_compare;
      A_STATUS:   w_rd_reg = status_o;
      A_CAUSE:    w_rd_reg = cause_o;
      A_EPC:      w_rd_reg = r_epc;
      default:    w_rd_reg = 32'd0;
    endcase
  end

  // Same-cycle write bypass shows the value the register will hold after the write.
  always_comb begin
    cp0_rdata_o = w_rd_reg;
    if (cp0_we_i && (cp0_waddr_i == cp0_raddr_i)) begin
      case (cp0_waddr_i)
        A_COUNT, A_COMPARE, A_EPC: cp0_rdata_o = cp0_wdata_i;
        A_STATUS: cp0_rdata_o = cp0_wdata_i & STATUS_WMASK;
        A_CAUSE:  cp0_rdata_o = {cause_o[31:10], cp0_wdata_i[9:8], cause_o[7:0]};
        default:  cp0_rdata_o = w_rd_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_handler_cp0.sv
// Bench for exc_handler_cp0: directed scenarios plus randomized traffic checked
// against a word-level CP0 model.
module tb_exc_handler_cp0;

  localparam logic [3:0] T_NONE = 4'd0;
  localparam logic [3:0] T_INT  = 4'd1;
  localparam logic [3:0] T_ADEL = 4'd2;
  localparam logic [3:0] T_ADES = 4'd3;
  localparam logic [3:0] T_SYS  = 4'd4;
  localparam logic [3:0] T_BP   = 4'd5;
  localparam logic [3:0] T_RI   = 4'd6;
  localparam logic [3:0] T_OV   = 4'd7;
  localparam logic [3:0] T_TR   = 4'd8;
  localparam logic [3:0] T_ERET = 4'd9;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk;
  logic        rst_n;
  logic [3:0]  exc_type;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_bad;
  logic        stall;
  logic [5:0]  hw_int;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic [31:0] status;
  logic [31:0] cause;
  logic        timer_int;
  logic        dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // Model: CP0 registers as full 32-bit words indexed by address.
  logic [31:0] m_reg [0:31];
  logic        m_timer;
  logic        m_flush;
  logic [31:0] m_redirect;

  exc_handler_cp0 dut (
    .clk(clk), .rst_n(rst_n), .exc_type_i(exc_type), .exc_pc_i(exc_pc),
    .exc_bd_i(exc_bd), .exc_badvaddr_i(exc_bad), .stall_i(stall), .hw_int_i(hw_int),
    .cp0_we_i(cp0_we), .cp0_waddr_i(cp0_waddr), .cp0_wdata_i(cp0_wdata),
    .cp0_raddr_i(cp0_raddr), .cp0_rdata_o(cp0_rdata), .flush_o(flush),
    .redirect_pc_o(redirect_pc), .epc_o(epc), .status_o(status), .cause_o(cause),
    .timer_int_o(timer_int), .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] code_of(input logic [3:0] t);
    case (t)
      T_INT:   return 5'd0;
      T_ADEL:  return 5'd4;
      T_ADES:  return 5'd5;
      T_SYS:   return 5'd8;
      T_BP:    return 5'd9;
      T_RI:    return 5'd10;
      T_OV:    return 5'd12;
      T_TR:    return 5'd13;
      default: return 5'd10;
    endcase
  endfunction

  function automatic logic [31:0] model_read();
    if (cp0_we && cp0_waddr == cp0_raddr) begin
      case (cp0_waddr)
        5'd9, 5'd11, 5'd14: return cp0_wdata;
        5'd12: return cp0_wdata & 32'h0000_FF03;
        5'd13: return (m_reg[13] & ~32'h300) | (cp0_wdata & 32'h300);
        default: ;
      endcase
    end
    return m_reg[cp0_raddr];
  endfunction

  task automatic model_update();
    logic [31:0] n [0:31];
    logic n_timer, n_flush, pend, take;
    logic [4:0] code;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
      m_timer = 1'b0; m_flush = 1'b0; m_redirect = 32'd0;
      return;
    end
    n = m_reg; n_timer = m_timer; n_flush = 1'b0; take = 1'b0; code = 5'd0;
    if (cp0_we) begin
      case (cp0_waddr)
        5'd9, 5'd11, 5'd14: n[cp0_waddr] = cp0_wdata;
        5'd12: n[12] = cp0_wdata & 32'h0000_FF03;
        5'd13: n[13] = (n[13] & ~32'h300) | (cp0_wdata & 32'h300);
        default: ;
      endcase
    end
    if (!(cp0_we && cp0_waddr == 5'd9)) n[9] = m_reg[9] + 32'd1;
    if (cp0_we && cp0_waddr == 5'd11) n_timer = 1'b0;
    else if (m_reg[9] == m_reg[11] && m_reg[11] != 32'd0) n_timer = 1'b1;
    n[13][15:10] = {hw_int[5] | m_timer, hw_int[4:0]};
    pend = ((m_reg[13][15:8] & m_reg[12][15:8]) != 8'd0) && m_reg[12][0] && !m_reg[12][1];
    if (!m_flush && !stall) begin
      if (pend) begin
        take = 1'b1; code = 5'd0;
      end else if (exc_type == T_ERET) begin
        n[12][1] = 1'b0; m_redirect = m_reg[14]; n_flush = 1'b1;
      end else if (exc_type != T_NONE) begin
        take = 1'b1; code = code_of(exc_type);
        if (exc_type == T_ADEL || exc_type == T_ADES) n[8] = exc_bad;
      end
    end
    if (take) begin
      if (!m_reg[12][1]) begin
        n[14] = exc_bd ? exc_pc - 32'd4 : exc_pc;
        n[13][31] = exc_bd;
      end
      n[12][1] = 1'b1; n[13][6:2] = code; m_redirect = VEC; n_flush = 1'b1;
    end
    m_reg = n; m_timer = n_timer; m_flush = n_flush;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    exc_type = T_NONE; exc_pc = 32'd0; exc_bd = 1'b0; exc_bad = 32'd0; stall = 1'b0;
    hw_int = 6'd0; cp0_we = 1'b0; cp0_waddr = 5'd0; cp0_wdata = 32'd0; cp0_raddr = 5'd0;
  endtask

  task automatic do_reset();
    idle(); rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle(); rst_n = 1'b0; tick(); tick();
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL rst_flush: got %b expected 0", flush); end
    n_cmp++; if (redirect_pc !== 32'd0) begin n_err++; $display("FAIL rst_redirect: got %h expected 0", redirect_pc); end
    n_cmp++; if (timer_int !== 1'b0) begin n_err++; $display("FAIL rst_timer: got %b expected 0", timer_int); end
    n_cmp++; if ({epc, status, cause} !== 96'd0) begin n_err++; $display("FAIL rst_regs: got %h %h %h expected 0", epc, status, cause); end
    for (int a = 8; a <= 14; a++) begin
      cp0_raddr = 5'(a); #1;
      n_cmp++; if (cp0_rdata !== 32'd0) begin n_err++; $display("FAIL rst_read%0d: got %h expected 0", a, cp0_rdata); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ov();
    do_reset();
    exc_type = T_OV; exc_pc = 32'h100; tick(); idle();
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL ov_flush: got %b expected 1", flush); end
    n_cmp++; if (redirect_pc !== VEC) begin n_err++; $display("FAIL ov_redirect: got %h expected %h", redirect_pc, VEC); end
    n_cmp++; if (epc !== 32'h100) begin n_err++; $display("FAIL ov_epc: got %h expected 100", epc); end
    n_cmp++; if (cause[6:2] !== 5'd12) begin n_err++; $display("FAIL ov_code: got %0d expected 12", cause[6:2]); end
    n_cmp++; if (status[1] !== 1'b1) begin n_err++; $display("FAIL ov_exl: got %b expected 1", status[1]); end
    tick();
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL ov_flush_end: got %b expected 0", flush); end
  endtask

  task automatic test_bd_eret();
    do_reset();
    exc_type = T_TR; exc_pc = 32'h204; exc_bd = 1'b1; tick(); idle();
    n_cmp++; if (epc !== 32'h200) begin n_err++; $display("FAIL bd_epc: got %h expected 200", epc); end
    n_cmp++; if (cause[31] !== 1'b1) begin n_err++; $display("FAIL bd_bit: got %b expected 1", cause[31]); end
    n_cmp++; if (cause[6:2] !== 5'd13) begin n_err++; $display("FAIL bd_code: got %0d expected 13", cause[6:2]); end
    tick();
    exc_type = T_ERET; tick(); idle();
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL eret_flush: got %b expected 1", flush); end
    n_cmp++; if (redirect_pc !== 32'h200) begin n_err++; $display("FAIL eret_redirect: got %h expected 200", redirect_pc); end
    n_cmp++; if (status[1] !== 1'b0) begin n_err++; $display("FAIL eret_exl: got %b expected 0", status[1]); end
    tick();
  endtask

  task automatic test_nested_exc();
    do_reset();
    exc_type = T_OV; exc_pc = 32'h100; tick(); idle(); tick();
    exc_type = T_RI; exc_pc = 32'h500; tick(); idle();
    n_cmp++; if (epc !== 32'h100) begin n_err++; $display("FAIL nest_epc: got %h expected 100", epc); end
    n_cmp++; if (cause[6:2] !== 5'd10) begin n_err++; $display("FAIL nest_code: got %0d expected 10", cause[6:2]); end
    n_cmp++; if (flush !== 1'b1 || redirect_pc !== VEC) begin n_err++; $display("FAIL nest_redirect: got %b/%h expected 1/%h", flush, redirect_pc, VEC); end
    tick();
  endtask

  task automatic test_timer();
    int hit;
    do_reset();
    cp0_we = 1'b1; cp0_waddr = 5'd11; cp0_wdata = 32'd5; tick();
    cp0_waddr = 5'd9; cp0_wdata = 32'd0; tick();
    idle();
    hit = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (timer_int) begin hit = i; break; end
    end
    n_cmp++; if (hit !== 6) begin n_err++; $display("FAIL timer_rise: got cycle %0d expected cycle 6", hit); end
    tick();
    n_cmp++; if (cause[15] !== 1'b1) begin n_err++; $display("FAIL timer_ip7: got %b expected 1", cause[15]); end
    cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h8001; tick();
    idle(); exc_pc = 32'h400; tick(); idle();
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL tint_flush: got %b expected 1", flush); end
    n_cmp++; if (cause[6:2] !== 5'd0) begin n_err++; $display("FAIL tint_code: got %0d expected 0", cause[6:2]); end
    n_cmp++; if (epc !== 32'h400) begin n_err++; $display("FAIL tint_epc: got %h expected 400", epc); end
    tick();
    cp0_we = 1'b1; cp0_waddr = 5'd11; cp0_wdata = 32'd7; tick(); idle();
    n_cmp++; if (timer_int !== 1'b0) begin n_err++; $display("FAIL timer_clear: got %b expected 0", timer_int); end
    tick();
    n_cmp++; if (cause[15] !== 1'b0) begin n_err++; $display("FAIL timer_ip7_clear: got %b expected 0", cause[15]); end
  endtask

  task automatic test_stall_reset();
    do_reset();
    exc_type = T_SYS; exc_pc = 32'h600; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL stall_flush%0d: got %b expected 0", i, flush); end
    end
    stall = 1'b0; tick();
    n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL stall_release: got %b expected 1", flush); end
    idle(); rst_n = 1'b0; tick();
    n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL rstflush_flush: got %b expected 0", flush); end
    n_cmp++; if ({epc, status, cause, redirect_pc} !== 128'd0) begin n_err++; $display("FAIL rstflush_regs: got %h %h %h %h expected 0", epc, status, cause, redirect_pc); end
    for (int a = 8; a <= 14; a++) begin
      cp0_raddr = 5'(a); #1;
      n_cmp++; if (cp0_rdata !== 32'd0) begin n_err++; $display("FAIL rstflush_read%0d: got %h expected 0", a, cp0_rdata); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mtc0_collide();
    do_reset();
    cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h1234; exc_type = T_OV; exc_pc = 32'h300;
    tick(); idle();
    n_cmp++; if (epc !== 32'h300) begin n_err++; $display("FAIL collide_epc: got %h expected 300", epc); end
    tick();
    cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'hFFFF_FFFF; cp0_raddr = 5'd12; #1;
    n_cmp++; if (cp0_rdata !== 32'h0000_FF03) begin n_err++; $display("FAIL bypass_status: got %h expected 0000ff03", cp0_rdata); end
    tick();
    n_cmp++; if (status !== 32'h0000_FF03) begin n_err++; $display("FAIL status_mask: got %h expected 0000ff03", status); end
    cp0_waddr = 5'd13; cp0_raddr = 5'd13; #1;
    n_cmp++; if (cp0_rdata !== 32'h330) begin n_err++; $display("FAIL bypass_cause: got %h expected 330", cp0_rdata); end
    tick(); idle();
    n_cmp++; if (cause !== 32'h330) begin n_err++; $display("FAIL cause_mask: got %h expected 330", cause); end
    cp0_we = 1'b1; cp0_waddr = 5'd8; cp0_wdata = 32'hDEAD_BEEF; tick(); idle();
    cp0_raddr = 5'd8; #1;
    n_cmp++; if (cp0_rdata !== 32'd0) begin n_err++; $display("FAIL badvaddr_ro: got %h expected 0", cp0_rdata); end
    cp0_raddr = 5'd10; #1;
    n_cmp++; if (cp0_rdata !== 32'd0) begin n_err++; $display("FAIL unimpl_read: got %h expected 0", cp0_rdata); end
    cp0_we = 1'b1; cp0_waddr = 5'd9; cp0_wdata = 32'hFFFF_FFFF; stall = 1'b1; tick();
    cp0_we = 1'b0; cp0_raddr = 5'd9; #1;
    n_cmp++; if (cp0_rdata !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL count_write: got %h expected ffffffff", cp0_rdata); end
    tick();
    n_cmp++; if (cp0_rdata !== 32'd0) begin n_err++; $display("FAIL count_wrap: got %h expected 0", cp0_rdata); end
    idle();
  endtask

  task automatic test_random();
    logic [3:0] types [0:9];
    logic [4:0] waddrs [0:7];
    logic [31:0] exp_rd;
    types = '{T_INT, T_ADEL, T_ADES, T_SYS, T_BP, T_RI, T_OV, T_TR, T_ERET, T_ERET};
    waddrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3, 5'd20};
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      exc_type  = ($urandom_range(0, 9) < 5) ? T_NONE : types[$urandom_range(0, 9)];
      exc_pc    = $urandom & 32'hFFFF_FFFC;
      exc_bd    = 1'($urandom_range(0, 1));
      exc_bad   = $urandom;
      stall     = ($urandom_range(0, 3) == 0);
      hw_int    = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
      cp0_we    = ($urandom_range(0, 3) == 0);
      cp0_waddr = waddrs[$urandom_range(0, 7)];
      cp0_wdata = (cp0_waddr == 5'd9 || cp0_waddr == 5'd11) ? 32'($urandom_range(0, 40)) : $urandom;
      cp0_raddr = ($urandom_range(0, 1) == 0) ? cp0_waddr : 5'($urandom_range(0, 31));
      #2;
      exp_rd = model_read();
      n_cmp++; if (cp0_rdata !== exp_rd) begin n_err++; $display("FAIL rnd_rdata c%0d a%0d: got %h expected %h", c, cp0_raddr, cp0_rdata, exp_rd); end
      tick();
      n_cmp++; if (flush !== m_flush) begin n_err++; $display("FAIL rnd_flush c%0d: got %b expected %b", c, flush, m_flush); end
      if (m_flush) begin
        n_cmp++; if (redirect_pc !== m_redirect) begin n_err++; $display("FAIL rnd_redirect c%0d: got %h expected %h", c, redirect_pc, m_redirect); end
      end
      n_cmp++; if (epc !== m_reg[14]) begin n_err++; $display("FAIL rnd_epc c%0d: got %h expected %h", c, epc, m_reg[14]); end
      n_cmp++; if (status !== m_reg[12]) begin n_err++; $display("FAIL rnd_status c%0d: got %h expected %h", c, status, m_reg[12]); end
      n_cmp++; if (cause !== m_reg[13]) begin n_err++; $display("FAIL rnd_cause c%0d: got %h expected %h", c, cause, m_reg[13]); end
      n_cmp++; if (timer_int !== m_timer) begin n_err++; $display("FAIL rnd_timer c%0d: got %b expected %b", c, timer_int, m_timer); end
    end
    idle(); rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_ov();
    test_bd_eret();
    test_nested_exc();
    test_timer();
    test_stall_reset();
    test_mtc0_collide();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
